// File: rtl/symbol_deframer_if.sv
// symbol_deframer_if
//   Byte-stream handshake between the symbol deframer and its consumer
//   (MAC/UART side).
//   tdata  : packed byte
//   tvalid : byte available (driven by master)
//   tready : consumer accepts (driven by slave)
//   tlast  : byte is the last one of a frame
interface symbol_deframer_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/symbol_deframer.sv
// symbol_deframer
//   Packs 2-bit QPSK symbols MSB-first into bytes, marks the last byte of
//   each frame, aborts frames that stall longer than GAP_TIMEOUT idle cycles,
//   and buffers bytes in a first-word-fall-through FIFO feeding a byte
//   stream. The symbol input can never be stalled; bytes that find the FIFO
//   full are dropped and flagged.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   in_valid       : symbol strobe
//   in_data[1:0]   : symbol
//   m_axis         : byte stream master (tdata/tvalid/tlast out, tready in)
//   overflow       : sticky, a byte was dropped on a full FIFO
//   frame_error    : one-cycle pulse when a frame is aborted by timeout
//   frame_count    : completed + aborted frames, wraps at 16 bits
module symbol_deframer #(
  parameter int FRAME_SYMS  = 63,
  parameter int FIFO_DEPTH  = 16,
  parameter int GAP_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [1:0]               in_data,
  symbol_deframer_if.master        m_axis,
  output logic                     overflow,
  output logic                     frame_error,
  output logic [15:0]              frame_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] LAST_SYM = 8'(FRAME_SYMS - 1);
  localparam logic [9:0] GAP_LAST = 10'(GAP_TIMEOUT - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t      state_reg;
  logic [7:0]  sym_cnt_reg;
  logic [9:0]  gap_cnt_reg;
  logic [7:0]  shift_reg;
  logic        overflow_reg;
  logic        frame_error_reg;
  logic [15:0] frame_count_reg;

  logic [8:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;

  // Symbol position inside the current byte, counted from frame start.
  logic [1:0] lane;
  logic [7:0] byte_now;
  logic       last_sym;
  logic       timeout;
  logic       push_req;
  logic [8:0] push_data;
  logic       fifo_empty;
  logic       fifo_full;
  logic       pop;
  logic       push_ok;

  assign lane = sym_cnt_reg[1:0];

  // Held symbols with the incoming symbol merged into its lane, so a byte
  // can be pushed on the same edge that captures its completing symbol.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_now[7-2*gi -: 2] = (lane == 2'(gi)) ? in_data
                                                      : shift_reg[7-2*gi -: 2];
    end
  endgenerate

  // In IDLE sym_cnt is 0, so the first symbol is handled exactly like any
  // other capture; FRAME_SYMS >= 4 keeps it from being the last one.
  assign last_sym  = (sym_cnt_reg == LAST_SYM);
  // A symbol arriving on the would-be timeout cycle suppresses the abort.
  assign timeout   = (state_reg == COLLECT) && !in_valid && (gap_cnt_reg == GAP_LAST);
  assign push_req  = (in_valid && ((lane == 2'd3) || last_sym)) || timeout;
  // On abort the held bits are already zero-padded; at a byte boundary the
  // shift register is zero, giving the all-zero tlast byte.
  assign push_data = timeout ? {1'b1, shift_reg} : {last_sym, byte_now};

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop        = !fifo_empty && m_axis.tready;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok    = push_req && (!fifo_full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      sym_cnt_reg     <= '0;
      gap_cnt_reg     <= '0;
      shift_reg       <= '0;
      overflow_reg    <= 1'b0;
      frame_error_reg <= 1'b0;
      frame_count_reg <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else begin
      frame_error_reg <= 1'b0;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (push_req && fifo_full && !pop)
        overflow_reg <= 1'b1;

      if (in_valid) begin
        gap_cnt_reg <= '0;
        if (last_sym) begin
          state_reg       <= IDLE;
          sym_cnt_reg     <= '0;
          shift_reg       <= '0;
          frame_count_reg <= frame_count_reg + 16'd1;
        end else begin
          state_reg   <= COLLECT;
          sym_cnt_reg <= sym_cnt_reg + 8'd1;
          shift_reg   <= (lane == 2'd3) ? 8'h00 : byte_now;
        end
      end else if (state_reg == COLLECT) begin
        if (timeout) begin
          state_reg       <= IDLE;
          sym_cnt_reg     <= '0;
          gap_cnt_reg     <= '0;
          shift_reg       <= '0;
          frame_error_reg <= 1'b1;
          frame_count_reg <= frame_count_reg + 16'd1;
        end else begin
          gap_cnt_reg <= gap_cnt_reg + 10'd1;
        end
      end
    end
  end

  // Storage is not reset; emptiness comes from the pointers alone.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  // Fall-through read; the output is forced to zero while empty so the
  // stream is clean after reset.
  assign m_axis.tvalid = !fifo_empty;
  assign {m_axis.tlast, m_axis.tdata} = fifo_empty ? 9'd0 : mem[rd_ptr_reg[AW-1:0]];

  assign overflow    = overflow_reg;
  assign frame_error = frame_error_reg;
  assign frame_count = frame_count_reg;
endmodule

// File: tb/tb_symbol_deframer.sv
module tb_symbol_deframer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  in_data = 2'd0;
  logic        overflow;
  logic        frame_error;
  logic [15:0] frame_count;

  symbol_deframer_if axis ();

  symbol_deframer #(.FRAME_SYMS(63), .FIFO_DEPTH(16), .GAP_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .m_axis(axis), .overflow(overflow), .frame_error(frame_error),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int err_pulses = 0;
  logic [8:0] rx_q[$];

  // Transfers are sampled mid-cycle; inputs only change 1ns after posedge.
  always @(negedge clk) begin
    if (!rst && axis.tvalid && axis.tready)
      rx_q.push_back({axis.tlast, axis.tdata});
    if (!rst && frame_error)
      err_pulses++;
  end

  typedef struct {
    logic [1:0] s0, s1, s2, s3;
    logic [7:0] exp;
  } pack_vec_t;
  pack_vec_t pv[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sym(input logic [1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
    rx_q.delete();
    err_pulses = 0;
  endtask

  initial begin
    pv[0] = '{2'd3, 2'd2, 2'd1, 2'd0, 8'hE4};
    pv[1] = '{2'd0, 2'd1, 2'd2, 2'd3, 8'h1B};
    pv[2] = '{2'd2, 2'd2, 2'd2, 2'd2, 8'hAA};
    pv[3] = '{2'd1, 2'd0, 2'd0, 2'd2, 8'h42};
    pv[4] = '{2'd0, 2'd0, 2'd0, 2'd0, 8'h00};
    pv[5] = '{2'd3, 2'd3, 2'd3, 2'd3, 8'hFF};
    axis.tready = 1'b1;

    // Reset state
    #3;
    check("rst_tvalid", 32'(axis.tvalid), 0);
    check("rst_tdata", 32'(axis.tdata), 0);
    check("rst_tlast", 32'(axis.tlast), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_frame_error", 32'(frame_error), 0);
    check("rst_frame_count", 32'(frame_count), 0);
    do_reset();

    // Nominal frame: 63 x 01
    for (int i = 0; i < 63; i++) sym(2'd1);
    idle(4);
    check("nom_bytes", 32'(rx_q.size()), 16);
    for (int k = 0; k < 16 && k < rx_q.size(); k++)
      check($sformatf("nom_byte%0d", k), 32'(rx_q[k]), (k < 15) ? 32'h055 : 32'h154);
    check("nom_frame_count", 32'(frame_count), 1);
    check("nom_overflow", 32'(overflow), 0);
    check("nom_err_pulses", 32'(err_pulses), 0);

    // Packing order and latency table, second frame
    rx_q.delete();
    for (int v = 0; v < 6; v++) begin
      sym(pv[v].s0);
      sym(pv[v].s1);
      sym(pv[v].s2);
      check($sformatf("pack%0d_tvalid_early", v), 32'(axis.tvalid), 0);
      sym(pv[v].s3);
      check($sformatf("pack%0d_tvalid", v), 32'(axis.tvalid), 1);
      check($sformatf("pack%0d_byte", v), 32'({axis.tlast, axis.tdata}), 32'({1'b0, pv[v].exp}));
    end
    for (int i = 24; i < 63; i++) sym(2'd0);
    idle(4);
    check("pack_frame_bytes", 32'(rx_q.size()), 16);
    if (rx_q.size() == 16) check("pack_last", 32'(rx_q[15]), 32'h100);
    check("pack_frame_count", 32'(frame_count), 2);

    // Gap timeout
    do_reset();
    for (int i = 0; i < 10; i++) sym(2'd3);
    idle(63);
    check("gap_err_before", 32'(frame_error), 0);
    idle(1);
    check("gap_err_pulse", 32'(frame_error), 1);
    check("gap_frame_count", 32'(frame_count), 1);
    idle(1);
    check("gap_err_after", 32'(frame_error), 0);
    sym(2'd3); sym(2'd0); sym(2'd0); sym(2'd0);
    idle(3);
    check("gap_bytes", 32'(rx_q.size()), 4);
    if (rx_q.size() == 4) begin
      check("gap_b0", 32'(rx_q[0]), 32'h0FF);
      check("gap_b1", 32'(rx_q[1]), 32'h0FF);
      check("gap_b2", 32'(rx_q[2]), 32'h1F0);
      check("gap_newframe", 32'(rx_q[3]), 32'h0C0);
    end
    check("gap_err_pulses", 32'(err_pulses), 1);

    // Timeout race: symbol on the 64th idle cycle wins
    do_reset();
    for (int i = 0; i < 8; i++) sym(2'd2);
    idle(63);
    for (int i = 0; i < 4; i++) sym(2'd1);
    idle(3);
    check("race_err_pulses", 32'(err_pulses), 0);
    check("race_frame_count", 32'(frame_count), 0);
    check("race_bytes", 32'(rx_q.size()), 3);
    if (rx_q.size() == 3) check("race_b2", 32'(rx_q[2]), 32'h055);

    // Backpressure and overflow
    do_reset();
    axis.tready = 1'b0;
    for (int i = 0; i < 63; i++) sym(2'((i / 4) % 4));
    idle(2);
    check("bp_overflow_full", 32'(overflow), 0);
    check("bp_tvalid", 32'(axis.tvalid), 1);
    check("bp_tdata_held", 32'({axis.tlast, axis.tdata}), 32'h000);
    for (int i = 0; i < 4; i++) sym(2'd1);
    check("bp_overflow_set", 32'(overflow), 1);
    check("bp_tdata_stable", 32'({axis.tlast, axis.tdata}), 32'h000);
    axis.tready = 1'b1;
    idle(20);
    check("bp_drained", 32'(rx_q.size()), 16);
    for (int k = 0; k < 16 && k < rx_q.size(); k++)
      check($sformatf("bp_byte%0d", k), 32'(rx_q[k]),
            (k < 15) ? 32'((k % 4) * 8'h55) : 32'h1FC);
    check("bp_tvalid_empty", 32'(axis.tvalid), 0);
    check("bp_overflow_sticky", 32'(overflow), 1);
    check("bp_frame_count", 32'(frame_count), 1);

    // Asynchronous reset mid-frame with bytes queued
    do_reset();
    for (int i = 0; i < 22; i++) sym(2'd2);
    axis.tready = 1'b0;
    for (int i = 0; i < 8; i++) sym(2'd2);
    check("ar_tvalid_before", 32'(axis.tvalid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_tvalid_async", 32'(axis.tvalid), 0);
    check("ar_tdata_async", 32'(axis.tdata), 0);
    #1;
    rst = 1'b0;
    step();
    rx_q.delete();
    axis.tready = 1'b1;
    check("ar_tvalid_after", 32'(axis.tvalid), 0);
    sym(2'd3);
    for (int i = 1; i < 63; i++) sym(2'd1);
    idle(4);
    check("ar_bytes", 32'(rx_q.size()), 16);
    if (rx_q.size() == 16) begin
      check("ar_b0", 32'(rx_q[0]), 32'h0D5);
      check("ar_b15", 32'(rx_q[15]), 32'h154);
    end
    check("ar_frame_count", 32'(frame_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "time limit");
  end
endmodule
